// File: rtl/chip_cmd_sequencer_pkg.sv
// Shared opcodes, response tags, field offsets and FSM state encoding for the
// chip command sequencer.
package chip_cmd_pkg;

   localparam logic [3:0] OP_NOP      = 4'h0;
   localparam logic [3:0] OP_SET_ITF  = 4'h1;
   localparam logic [3:0] OP_WRITE    = 4'h2;
   localparam logic [3:0] OP_READ     = 4'h3;
   localparam logic [3:0] OP_WAIT_WEI = 4'h4;
   localparam logic [3:0] OP_WAIT_ACT = 4'h5;
   localparam logic [3:0] OP_STATUS   = 4'h6;

   localparam logic [3:0] TAG_RD  = 4'hA;
   localparam logic [3:0] TAG_STA = 4'h5;
   localparam logic [3:0] TAG_ERR = 4'hE;

   localparam logic [15:0] ERR_TIMEOUT = 16'h0001;
   localparam logic [15:0] ERR_ILLEGAL = 16'h0002;

   localparam int OP_LSB   = 28;
   localparam int RSVD_LSB = 24;
   localparam int ADDR_LSB = 16;
   localparam int DATA_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_EXEC,
      ST_SER,
      ST_WAIT,
      ST_PUSH
   } seq_state_t;

   function automatic logic [31:0] make_resp(input logic [3:0]  tag,
                                             input logic [3:0]  op,
                                             input logic [7:0]  addr,
                                             input logic [15:0] payload);
      return {tag, op, addr, payload};
   endfunction

endpackage

// File: rtl/chip_cmd_sequencer_if.sv
// Host FIFO and serial-master signals seen by the command sequencer.
// master = sequencer side, slave = FIFO / serial master side.
interface chip_cmd_sequencer_if;

   logic [31:0] fifoa_dout;
   logic        fifoa_empty;
   logic        fifoa_ren;
   logic [31:0] fifob_din;
   logic        fifob_full;
   logic        fifob_wen;
   logic        ser_req;
   logic        ser_rw;
   logic [7:0]  ser_addr;
   logic [15:0] ser_wdata;
   logic        ser_ack;
   logic [15:0] ser_rdata;

   modport master (
      input  fifoa_dout, fifoa_empty, fifob_full, ser_ack, ser_rdata,
      output fifoa_ren, fifob_din, fifob_wen, ser_req, ser_rw, ser_addr, ser_wdata
   );

   modport slave (
      output fifoa_dout, fifoa_empty, fifob_full, ser_ack, ser_rdata,
      input  fifoa_ren, fifob_din, fifob_wen, ser_req, ser_rw, ser_addr, ser_wdata
   );

endinterface

// File: rtl/chip_cmd_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous chip status lines.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/chip_cmd_sequencer.sv
// Command sequencer: pops command words from FIFO A, runs serial transactions or
// status waits, and pushes read-data / status / error words to FIFO B.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for FIFO A word; pulses fifoa_ren when not empty
//  ST_FETCH | FIFO A read latency cycle
//  ST_LATCH | capture fifoa_dout into cmd_q
//  ST_EXEC  | decode cmd_q, apply SET_ITF / build status or error word
//  ST_SER   | serial request held until ser_ack
//  ST_WAIT  | waiting for synced status with timeout
//  ST_PUSH  | hold fifob_din, write once FIFO B has room
module chip_cmd_sequencer
   import chip_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYC = 640000,
   parameter int TMO_W       = 20
) (
   input  logic                 CLK,
   input  logic                 rst,
   chip_cmd_sequencer_if.master bus,
   input  logic                 sta_wei,
   input  logic                 sta_act,
   output logic                 itf_sel,
   output logic                 busy,
   output logic                 err
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   seq_state_t state_q, state_d;

   logic [31:0]      cmd_q;
   logic [31:0]      resp_q, resp_d;
   logic [TMO_W-1:0] tmo_q;
   logic             itf_q;
   logic             err_q;

   logic cmd_ld, itf_ld, err_set, resp_ld, tmo_clr, tmo_inc;
   logic sta_wei_s, sta_act_s;
   logic wait_hit;

   logic [3:0]  cmd_op;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_data;

   sync_2ff u_sync_wei (
      .clk (CLK),
      .rst (rst),
      .d   (sta_wei),
      .q   (sta_wei_s)
   );

   sync_2ff u_sync_act (
      .clk (CLK),
      .rst (rst),
      .d   (sta_act),
      .q   (sta_act_s)
   );

   assign cmd_op   = cmd_q[OP_LSB +: 4];
   assign cmd_addr = cmd_q[ADDR_LSB +: 8];
   assign cmd_data = cmd_q[DATA_LSB +: 16];

   // Reserved nibble is carried in cmd_q but never interpreted.
   wire unused_rsvd = ^cmd_q[RSVD_LSB +: 4];

   assign wait_hit = (cmd_op == OP_WAIT_WEI) ? sta_wei_s : sta_act_s;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_ld  = 1'b0;
      itf_ld  = 1'b0;
      err_set = 1'b0;
      resp_ld = 1'b0;
      resp_d  = resp_q;
      tmo_clr = 1'b0;
      tmo_inc = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!bus.fifoa_empty) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            cmd_ld  = 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            tmo_clr = 1'b1;
            case (cmd_op)
               OP_NOP: begin
                  state_d = ST_IDLE;
               end
               OP_SET_ITF: begin
                  itf_ld  = 1'b1;
                  state_d = ST_IDLE;
               end
               OP_WRITE, OP_READ: begin
                  state_d = ST_SER;
               end
               OP_WAIT_WEI, OP_WAIT_ACT: begin
                  state_d = ST_WAIT;
               end
               OP_STATUS: begin
                  resp_ld = 1'b1;
                  resp_d  = make_resp(TAG_STA, cmd_op, cmd_addr,
                                      {13'd0, err_q, sta_wei_s, sta_act_s});
                  state_d = ST_PUSH;
               end
               default: begin
                  err_set = 1'b1;
                  resp_ld = 1'b1;
                  resp_d  = make_resp(TAG_ERR, cmd_op, cmd_addr, ERR_ILLEGAL);
                  state_d = ST_PUSH;
               end
            endcase
         end
         ST_SER: begin
            if (bus.ser_ack) begin
               if (cmd_op == OP_READ) begin
                  resp_ld = 1'b1;
                  resp_d  = make_resp(TAG_RD, cmd_op, cmd_addr, bus.ser_rdata);
                  state_d = ST_PUSH;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            // Status wins over timeout when both land in the same cycle.
            if (wait_hit) begin
               tmo_clr = 1'b1;
               state_d = ST_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               tmo_clr = 1'b1;
               err_set = 1'b1;
               resp_ld = 1'b1;
               resp_d  = make_resp(TAG_ERR, cmd_op, cmd_addr, ERR_TIMEOUT);
               state_d = ST_PUSH;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         ST_PUSH: begin
            if (!bus.fifob_full) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         cmd_q  <= '0;
         resp_q <= '0;
         tmo_q  <= '0;
         itf_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (cmd_ld)  cmd_q  <= bus.fifoa_dout;
         if (itf_ld)  itf_q  <= cmd_data[0];
         if (err_set) err_q  <= 1'b1;
         if (resp_ld) resp_q <= resp_d;
         if (tmo_clr) begin
            tmo_q <= '0;
         end else if (tmo_inc) begin
            tmo_q <= tmo_q + 1'b1;
         end
      end
   end

   // rst gates the read strobe so a non-empty FIFO A is never popped in reset.
   assign bus.fifoa_ren = (state_q == ST_IDLE) && !bus.fifoa_empty && !rst;
   assign bus.fifob_wen = (state_q == ST_PUSH) && !bus.fifob_full;
   assign bus.fifob_din = resp_q;
   assign bus.ser_req   = (state_q == ST_SER);
   assign bus.ser_rw    = (cmd_op == OP_READ);
   assign bus.ser_addr  = cmd_addr;
   assign bus.ser_wdata = cmd_data;

   assign itf_sel = itf_q;
   assign busy    = (state_q != ST_IDLE);
   assign err     = err_q;

endmodule

// File: tb/tb_chip_cmd_sequencer.sv
// Directed bench for chip_cmd_sequencer: vector table of single commands plus
// hand-written wait/timeout, FIFO B back-pressure and mid-transaction reset cases.
module tb_chip_cmd_sequencer;

   localparam int TMO = 200;

   logic CLK = 1'b0;
   logic rst = 1'b1;
   logic sta_wei = 1'b0;
   logic sta_act = 1'b0;
   logic itf_sel, busy, err;

   chip_cmd_sequencer_if bus ();

   chip_cmd_sequencer #(.TIMEOUT_CYC(TMO), .TMO_W(20)) dut (
      .CLK     (CLK),
      .rst     (rst),
      .bus     (bus),
      .sta_wei (sta_wei),
      .sta_act (sta_act),
      .itf_sel (itf_sel),
      .busy    (busy),
      .err     (err)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   // FIFO A model
   logic [31:0] fa_mem [0:63];
   int fa_wr = 0;
   int fa_rd = 0;
   assign bus.fifoa_empty = (fa_wr == fa_rd);
   always @(posedge CLK) begin
      if (bus.fifoa_ren) begin
         bus.fifoa_dout <= fa_mem[fa_rd[5:0]];
         fa_rd <= fa_rd + 1;
      end
   end

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // FIFO B capture and protocol monitor
   logic [31:0] fb_mem [0:63];
   int fb_cnt = 0;
   int mon_viol = 0;
   int ren_cyc = 0;
   int wen_cyc = 0;
   always @(negedge CLK) begin
      if (bus.fifoa_ren) begin
         ren_cyc <= cyc;
         if (bus.fifoa_empty || busy) mon_viol <= mon_viol + 1;
      end
      if (bus.fifob_wen) begin
         if (bus.fifob_full) mon_viol <= mon_viol + 1;
         fb_mem[fb_cnt[5:0]] <= bus.fifob_din;
         fb_cnt <= fb_cnt + 1;
         wen_cyc <= cyc;
      end
   end

   // Serial master model
   int          ser_delay = 3;
   logic [15:0] ser_rdata_v = 16'h0;
   int          ser_cnt = 0;
   int          ser_viol = 0;
   logic [7:0]  s_addr = 8'h0;
   logic        s_rw = 1'b0;
   logic [15:0] s_wdata = 16'h0;
   initial begin
      bit aborted;
      bus.ser_ack   = 1'b0;
      bus.ser_rdata = 16'h0;
      forever begin
         @(negedge CLK);
         if (bus.ser_req === 1'b1) begin
            s_addr  = bus.ser_addr;
            s_rw    = bus.ser_rw;
            s_wdata = bus.ser_wdata;
            ser_cnt = ser_cnt + 1;
            aborted = 1'b0;
            for (int i = 1; i < ser_delay && !aborted; i++) begin
               @(negedge CLK);
               if (!bus.ser_req) aborted = 1'b1;
               else if (bus.ser_addr !== s_addr || bus.ser_rw !== s_rw ||
                        bus.ser_wdata !== s_wdata) ser_viol = ser_viol + 1;
            end
            if (!aborted) begin
               bus.ser_ack   = 1'b1;
               bus.ser_rdata = ser_rdata_v;
               @(negedge CLK);
               bus.ser_ack   = 1'b0;
               bus.ser_rdata = 16'h0;
               if (bus.ser_req) ser_viol = ser_viol + 1;
            end
         end
      end
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [31:0] w);
      fa_mem[fa_wr[5:0]] = w;
      fa_wr = fa_wr + 1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!busy && n < 20) begin @(negedge CLK); n++; end
      n = 0;
      while (busy && n < 2000) begin @(negedge CLK); n++; end
      check32({name, "_done"}, {31'd0, busy}, 32'd0);
      @(negedge CLK);
   endtask

   task automatic wait_ren(input string name);
      int n;
      n = 0;
      #1;
      while (!bus.fifoa_ren && n < 20) begin @(negedge CLK); #1; n++; end
      check32({name, "_ren"}, {31'd0, bus.fifoa_ren}, 32'd1);
   endtask

   typedef struct {
      logic [31:0] cmd;
      int          dly;
      logic [15:0] rdata;
      int          exp_push;
      logic [31:0] exp_word;
      logic        exp_itf;
      logic        exp_err;
      logic        chk_ser;
      logic        exp_rw;
      logic [7:0]  exp_addr;
      logic [15:0] exp_wdata;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #1ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fb0;
      int sc0;
      int stable_bad;
      int wen_bad;
      logic [31:0] word0;

      vecs[0]  = '{32'h1000_0001, 3, 16'h0,    0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
      vecs[1]  = '{32'h1000_0000, 3, 16'h0,    0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
      vecs[2]  = '{32'h0000_0000, 3, 16'h0,    0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
      vecs[3]  = '{32'h2055_A5A5, 3, 16'h0,    0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 16'hA5A5};
      vecs[4]  = '{32'h3012_0000, 5, 16'hBEEF, 1, 32'hA312_BEEF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 16'h0000};
      vecs[5]  = '{32'h6033_0000, 3, 16'h0,    1, 32'h5633_0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
      vecs[6]  = '{32'hF0AB_1234, 3, 16'h0,    1, 32'hEFAB_0002, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
      vecs[7]  = '{32'h6033_0000, 3, 16'h0,    1, 32'h5633_0004, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
      vecs[8]  = '{32'h1000_0003, 3, 16'h0,    0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
      vecs[9]  = '{32'h7000_0000, 3, 16'h0,    1, 32'hE700_0002, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
      vecs[10] = '{32'h3080_0000, 1, 16'h1234, 1, 32'hA380_1234, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 16'h0000};
      vecs[11] = '{32'h0000_0000, 3, 16'h0,    0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};

      bus.fifob_full = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge CLK);
      check32("reset_bus", {bus.fifoa_ren, bus.fifob_wen, bus.ser_req, bus.ser_rw,
                            bus.ser_addr, 20'd0}, 32'd0);
      check32("reset_din", bus.fifob_din, 32'd0);
      check32("reset_flags", {29'd0, itf_sel, busy, err}, 32'd0);
      rst = 1'b0;
      @(negedge CLK);

      // WAIT_WEI satisfied after 100 cycles
      fb0 = fb_cnt;
      push_a(32'h4000_0000);
      repeat (100) @(negedge CLK);
      sta_wei = 1'b1;
      wait_idle("wait_wei_ok");
      check32("wait_wei_ok_push", fb_cnt - fb0, 0);
      check32("wait_wei_ok_err", {31'd0, err}, 32'd0);
      sta_wei = 1'b0;
      repeat (4) @(negedge CLK);
      push_a(32'h1000_0001);
      wait_idle("next_cmd");
      check32("next_cmd_itf", {31'd0, itf_sel}, 32'd1);
      check32("next_cmd_fifoa", fa_wr - fa_rd, 0);

      // synced status in the last counted cycle still succeeds
      fb0 = fb_cnt;
      push_a(32'h5000_0000);
      wait_ren("act_edge");
      repeat (TMO + 1) @(negedge CLK);
      sta_act = 1'b1;
      wait_idle("act_edge");
      check32("act_edge_push", fb_cnt - fb0, 0);
      check32("act_edge_err", {31'd0, err}, 32'd0);
      sta_act = 1'b0;
      repeat (4) @(negedge CLK);

      // one cycle later is a timeout
      fb0 = fb_cnt;
      push_a(32'h5000_0000);
      wait_ren("act_late");
      repeat (TMO + 2) @(negedge CLK);
      sta_act = 1'b1;
      wait_idle("act_late");
      check32("act_late_push", fb_cnt - fb0, 1);
      check32("act_late_word", fb_mem[fb0[5:0]], 32'hE500_0001);
      check32("act_late_err", {31'd0, err}, 32'd1);
      sta_act = 1'b0;
      repeat (4) @(negedge CLK);

      // status never arrives
      fb0 = fb_cnt;
      push_a(32'h4000_0000);
      wait_idle("wei_tmo");
      check32("wei_tmo_push", fb_cnt - fb0, 1);
      check32("wei_tmo_word", fb_mem[fb0[5:0]], 32'hE400_0001);
      check32("wei_tmo_latency", wen_cyc - ren_cyc, TMO + 4);
      check32("wei_tmo_err", {31'd0, err}, 32'd1);

      rst = 1'b1;
      repeat (2) @(negedge CLK);
      check32("rst_clears_err_itf", {30'd0, itf_sel, err}, 32'd0);
      rst = 1'b0;
      @(negedge CLK);

      for (int v = 0; v < 12; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         ser_delay   = vecs[v].dly;
         ser_rdata_v = vecs[v].rdata;
         fb0 = fb_cnt;
         sc0 = ser_cnt;
         push_a(vecs[v].cmd);
         wait_idle(nm);
         check32({nm, "_push"}, fb_cnt - fb0, vecs[v].exp_push);
         if (vecs[v].exp_push != 0)
            check32({nm, "_word"}, fb_mem[fb0[5:0]], vecs[v].exp_word);
         check32({nm, "_itf_err"}, {30'd0, itf_sel, err}, {30'd0, vecs[v].exp_itf, vecs[v].exp_err});
         if (vecs[v].chk_ser) begin
            check32({nm, "_ser_cnt"}, ser_cnt - sc0, 1);
            check32({nm, "_ser_fields"}, {7'd0, s_rw, s_addr, s_wdata},
                    {7'd0, vecs[v].exp_rw, vecs[v].exp_addr, vecs[v].exp_wdata});
         end
      end

      // STATUS while FIFO B is full for 20 cycles
      bus.fifob_full = 1'b1;
      fb0 = fb_cnt;
      push_a(32'h6000_0000);
      wait_ren("full");
      repeat (5) @(negedge CLK);
      word0 = bus.fifob_din;
      stable_bad = 0;
      wen_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (bus.fifob_din !== word0) stable_bad++;
         if (bus.fifob_wen !== 1'b0) wen_bad++;
      end
      check32("full_word", word0, 32'h5600_0004);
      check32("full_stable", stable_bad, 0);
      check32("full_no_wen", wen_bad, 0);
      check32("full_no_write", fb_cnt - fb0, 0);
      bus.fifob_full = 1'b0;
      wait_idle("full");
      check32("full_one_write", fb_cnt - fb0, 1);
      check32("full_written_word", fb_mem[fb0[5:0]], 32'h5600_0004);

      // reset while the serial request is pending
      ser_delay = 50;
      fb0 = fb_cnt;
      push_a(32'h3012_0000);
      begin
         int n;
         n = 0;
         while (!bus.ser_req && n < 20) begin @(negedge CLK); n++; end
      end
      check32("rst_ser_req_seen", {31'd0, bus.ser_req}, 32'd1);
      rst = 1'b1;
      @(negedge CLK);
      check32("rst_ser_bus", {bus.fifoa_ren, bus.fifob_wen, bus.ser_req, bus.ser_rw,
                              bus.ser_addr, 20'd0}, 32'd0);
      check32("rst_ser_wdata_din", {bus.ser_wdata, 16'd0} | bus.fifob_din, 32'd0);
      check32("rst_ser_flags", {29'd0, itf_sel, busy, err}, 32'd0);
      rst = 1'b0;
      @(negedge CLK);
      push_a(32'h1000_0001);
      wait_idle("restart");
      check32("restart_itf", {31'd0, itf_sel}, 32'd1);
      check32("restart_no_push", fb_cnt - fb0, 0);
      check32("restart_fifoa", fa_wr - fa_rd, 0);

      check32("protocol_monitor", mon_viol, 0);
      check32("serial_stability", ser_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
